alu_issue_ctrl: RTL

Sequencing stage wrapped around the combinational 8-bit ALU. Accepts one command (operands plus opcode) over a valid/ready handshake and drives the ALU inputs from registers. Captures the ALU result and carry one cycle later, then presents result, carry and zero flag over a second valid/ready handshake. Sits between the command source (bus or test driver) and the ALU, and makes the ALU usable in clocked pipelines.

---
 rtl/alu_issue_ctrl.sv | 84 ++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing stage around the combinational ALU.
// Registers one command, captures the ALU result, holds the response.
module alu_issue_ctrl #(
  parameter int WIDTH     = 8,
  parameter int OP_WIDTH  = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  input  logic [OP_WIDTH-1:0]  cmd_op,
  output logic [WIDTH-1:0]     operand_a,
  output logic [WIDTH-1:0]     operand_b,
  output logic [OP_WIDTH-1:0]  operation,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_carry,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_result,
  output logic                 rsp_carry,
  output logic                 rsp_zero,
  output logic [OP_WIDTH-1:0]  rsp_op,
  output logic [CNT_WIDTH-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t state;

  // Ready is masked by rst so nothing is offered during reset.
  assign cmd_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      operand_a  <= '0;
      operand_b  <= '0;
      operation  <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_op     <= '0;
      op_count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            operand_a <= cmd_a;
            operand_b <= cmd_b;
            operation <= cmd_op;
            state     <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_carry  <= alu_carry;
          rsp_zero   <= (alu_result == '0);
          rsp_op     <= operation;
          rsp_valid  <= 1'b1;
          op_count   <= op_count + CNT_ONE;
          state      <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
